// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mc_pkg;

  // Controller states; 4-bit encoding leaves three unused codes.
  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump,
    StHalt
  } state_e;

  // Opcodes (instr[31:26]).
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes (instr[5:0]).
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU operation class selected by the FSM.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_e;

  // ALU control encodings seen by the datapath.
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  // Sticky fault code.
  typedef enum logic [1:0] {
    ErrNone    = 2'b00,
    ErrIllegal = 2'b01,
    ErrTimeout = 2'b10
  } err_e;

  // Datapath mux selects.
  localparam logic [1:0] SrcbRt    = 2'b00;
  localparam logic [1:0] SrcbFour  = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbImmSh = 2'b11;

  localparam logic [1:0] PcsrcAlu    = 2'b00;
  localparam logic [1:0] PcsrcAluOut = 2'b01;
  localparam logic [1:0] PcsrcJump   = 2'b10;

  // States that wait on the memory handshake and are subject to the timeout.
  function automatic logic is_mem_wait(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();

  // Datapath -> controller
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;

  // Controller -> datapath
  logic             pcen;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [2:0]       alucontrol;
  logic             halted;
  logic [1:0]       err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, halted, err, instret
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, halted, err, instret
  );

endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's operation class and the funct field to ALU control.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_illegal_o
);

  // Decode operation class; funct only matters for R-type execution.
  always_comb begin
    alucontrol_o    = AluAdd;
    funct_illegal_o = 1'b0;
    case (aluop_i)
      AluOpAdd: alucontrol_o = AluAdd;
      AluOpSub: alucontrol_o = AluSub;
      AluOpFunct: begin
        case (funct_i)
          FnAdd:   alucontrol_o = AluAdd;
          FnSub:   alucontrol_o = AluSub;
          FnAnd:   alucontrol_o = AluAnd;
          FnOr:    alucontrol_o = AluOr;
          FnSlt:   alucontrol_o = AluSlt;
          default: begin
            alucontrol_o    = AluAnd;
            funct_illegal_o = 1'b1;
          end
        endcase
      end
      default: alucontrol_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS: decode, datapath control, memory
// stall handling, timeout/illegal-instruction halt and retired-instruction count.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  err_e             err_q, err_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       retire;
  logic       tmo_hit;
  logic       iord, memread, memwrite, irwrite, pcwrite, branch;
  logic       regdst, memtoreg, regwrite, alusrca, alu_en;
  logic [1:0] alusrcb, pcsrc;
  aluop_e     aluop;
  logic [2:0] dec_alu;
  logic       funct_illegal;

  mc_aludec u_aludec (
    .aluop_i        (aluop),
    .funct_i        (bus.funct),
    .alucontrol_o   (dec_alu),
    .funct_illegal_o(funct_illegal)
  );

  // Last permitted wait cycle; with mem_ready still low the access is abandoned.
  assign tmo_hit = (cnt_q == TLast);

  // Next-state and Moore datapath controls.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    retire   = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SrcbRt;
    pcsrc    = PcsrcAlu;
    aluop    = AluOpAdd;
    alu_en   = 1'b0;
    unique case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = SrcbFour;
        alu_en  = 1'b1;
        if (bus.mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = StDecode;
        end else if (tmo_hit) begin
          state_d = StHalt;
          err_d   = ErrTimeout;
        end
      end
      StDecode: begin
        alusrcb = SrcbImmSh;
        alu_en  = 1'b1;
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d = StHalt;
            err_d   = ErrIllegal;
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = SrcbImm;
        alu_en  = 1'b1;
        state_d = (bus.op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (bus.mem_ready) begin
          state_d = StMemWb;
        end else if (tmo_hit) begin
          state_d = StHalt;
          err_d   = ErrTimeout;
        end
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.mem_ready) begin
          retire = 1'b1;
        end else if (tmo_hit) begin
          state_d = StHalt;
          err_d   = ErrTimeout;
        end
      end
      StExec: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
        alu_en  = 1'b1;
        if (funct_illegal) begin
          state_d = StHalt;
          err_d   = ErrIllegal;
        end else begin
          state_d = StAluWb;
        end
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      StBranch: begin
        alusrca = 1'b1;
        aluop   = AluOpSub;
        pcsrc   = PcsrcAluOut;
        branch  = 1'b1;
        alu_en  = 1'b1;
        retire  = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = SrcbImm;
        alu_en  = 1'b1;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      StJump: begin
        pcsrc   = PcsrcJump;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
    if (retire) begin
      state_d = StFetch;
    end
  end

  // Wait-cycle counter: restarts on every state change, advances while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (is_mem_wait(state_q) && !bus.mem_ready) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // State, fault and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      err_q     <= ErrNone;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  // Write/request strobes are gated by reset so nothing fires while it is held.
  assign bus.pcen       = (pcwrite | (branch & bus.zero)) & reset;
  assign bus.memread    = memread & reset;
  assign bus.memwrite   = memwrite & reset;
  assign bus.irwrite    = irwrite & reset;
  assign bus.regwrite   = regwrite & reset;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alu_en ? dec_alu : 3'b000;
  assign bus.halted     = (state_q == StHalt);
  assign bus.err        = err_q;
  assign bus.instret    = instret_q;

endmodule
